lsu: RTL and testbench
======================

# lsu

Load/store unit between the RV32I execute stage and the word-organised data memory. It accepts one load or store request at a time over a valid/ready handshake and performs RV32I byte/half/word alignment and load sign/zero extension. Sub-word stores become a read-modify-write, because the memory writes whole 32-bit words only. It drives the memory's byte address, store data and write enable, and consumes its combinational read data.

## Interface
- DEPTH, 2048: data memory size in bytes; power of two, multiple of 4.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- rsp_valid  out  1  response present; held until taken.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-funct3 request.
- mem_addr  out  $clog2(DEPTH)  byte address to memory.
- mem_sdata  out  32  full word to write.
- mem_wren  out  1  memory write enable.
- mem_ldata  in  32  memory read data; combinational from mem_addr.

## Operation
- The request is accepted on a clock edge where req_valid && req_ready. All request fields are registered; the inputs are then don't-care.
- FSM states: IDLE, READ, WRITE, LOAD, RESP.
- IDLE: req_ready = 1. On acceptance, the request is first checked for errors:
  - An error goes directly to RESP with rsp_err = 1 and rsp_rdata = 0. The memory is not written.
  - Loads go to LOAD.
  - SW goes to WRITE.
  - SB and SH go to READ.
- Error conditions:
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Out of range: req_addr ≥ DEPTH.
  - Illegal funct3: load funct3 of 011, 110 or 111; store funct3 other than 000, 001 or 010.
- LOAD: mem_addr = registered address. On the edge, the formatted mem_ldata is captured into rsp_rdata. Next state is RESP.
  - Byte lane k is bits [8k+7:8k] (little-endian).
  - LB/LBU select lane addr[1:0].
  - LH/LHU select half addr[1] (bits [16·addr[1]+15 : 16·addr[1]]).
  - LB/LH sign-extend the selected data; LBU/LHU zero-extend it.
- READ: mem_addr = registered address. On the edge, mem_ldata is captured as the old word. Next state is WRITE.
- WRITE: mem_wren = 1 and mem_addr = registered address.
  - SW: mem_sdata = wdata.
  - SB: mem_sdata = old word with lane addr[1:0] replaced by wdata[7:0].
  - SH: mem_sdata = old word with half addr[1] replaced by wdata[15:0].
  - Next state is RESP, with rsp_rdata = 0 and rsp_err = 0.
- RESP: rsp_valid = 1, and rsp_rdata/rsp_err stay stable. If rsp_ready, return to IDLE; otherwise remain in RESP.
- Outside WRITE: mem_wren = 0 and mem_sdata = 0.
- In IDLE and RESP, mem_addr holds the last registered address (0 after reset).

## Timing
- Acceptance edge is in cycle N.
  - Load: LOAD in cycle N+1, rsp_valid from N+2.
  - SW: write edge ends cycle N+1, rsp_valid from N+2.
  - SB/SH: READ in N+1, write edge ends N+2, rsp_valid from N+3.
  - Error: rsp_valid from N+1.
- One outstanding request. req_ready = 0 in every state other than IDLE.
- Earliest next acceptance is in the cycle after the rsp_valid && rsp_ready edge.
- rsp_valid, rsp_rdata and rsp_err must not change while rsp_valid = 1 and rsp_ready = 0.
- Reset: while rst_n = 0, req_ready, rsp_valid and mem_wren are forced to 0 combinationally. The gating of mem_wren ensures no memory write occurs on a reset edge, even mid-WRITE.
- At a reset edge: state ← IDLE, registered address/data ← 0, rsp_rdata ← 0, rsp_err ← 0.
- A request is abandoned when reset hits it in any state; no response is produced.
- First acceptance is possible in the first cycle with rst_n = 1.

## Test plan
- Store-load round trip: SW 0x8000_00F1 at address 0x10, then LB/LBU/LH/LHU/LW at 0x10.
  - Required: LB = 0xFFFF_FFF1, LBU = 0x0000_00F1, LH = 0x0000_00F1, LHU = 0x0000_00F1, LW = 0x8000_00F1.
  - Required: rsp_valid two cycles after each acceptance.
- Sub-word RMW: SW 0x1122_3344 at 0x20, SB 0xAB at 0x22, SH 0xCDEF at 0x20.
  - Required after the SB: LW returns 0x11AB_3344.
  - Required after the SH: LW returns 0x11AB_CDEF.
  - Required: each SB/SH responds three cycles after acceptance, with exactly one mem_wren cycle.
- Errors: LW at 0x22, SH at 0x21, LB at 2048, and a store with funct3 100.
  - Required: each gives rsp_err = 1 and rsp_rdata = 0 one cycle after acceptance, with mem_wren never asserted.
  - Required: memory is unchanged, verified by LW reads.
- Backpressure: hold rsp_ready = 0 for 5 cycles after an LH of 0x8001 at addr[1] = 1.
  - Required: rsp_valid and rsp_rdata = 0xFFFF_8001 stay stable, and req_ready stays 0.
  - Required: after rsp_ready = 1, the next request is accepted the following cycle.
- Reset mid-RMW: assert rst_n = 0 in the WRITE cycle of an SB.
  - Required: mem_wren = 0 in that cycle, the memory word is unchanged, no response is produced, and req_ready = 1 after release.
- Back-to-back traffic: 1000 random aligned and misaligned requests with rsp_ready always 1.
  - Required: responses are in order and match a reference model.

Source files
------------

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : RV32I load/store unit; byte/half/word alignment, load extension,
//            and read-modify-write for sub-word stores to a word-only memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_sdata,
    output logic                     mem_wren,
    input  logic [31:0]              mem_ldata
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_LOAD  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;
    logic [31:0]   r_old;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_misal;
    logic          w_oor;
    logic          w_illegal;
    logic          w_error;
    logic [7:0]    w_lbyte;
    logic [15:0]   w_lhalf;
    logic [31:0]   w_ldata;
    logic [31:0]   w_sdata;

    // Handshake outputs are gated by reset so nothing escapes on a reset edge.
    assign req_ready = rst_n && (r_state == S_IDLE);
    assign rsp_valid = rst_n && (r_state == S_RESP);
    assign mem_wren  = rst_n && (r_state == S_WRITE);
    assign mem_addr  = r_addr;
    assign mem_sdata = w_sdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept  = req_valid && req_ready;
    assign w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oor     = (req_addr >= 32'(DEPTH));
    assign w_illegal = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign w_error   = w_misal || w_oor || w_illegal;

    assign w_lbyte = mem_ldata[{r_addr[1:0], 3'b000} +: 8];
    assign w_lhalf = r_addr[1] ? mem_ldata[31:16] : mem_ldata[15:0];

    always_comb begin
        w_ldata = mem_ldata;
        case (r_funct3)
            3'b000:  w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
            3'b001:  w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
            3'b100:  w_ldata = {24'd0, w_lbyte};
            3'b101:  w_ldata = {16'd0, w_lhalf};
            default: w_ldata = mem_ldata;
        endcase
    end

    // Merge the new byte/half into the word captured during READ.
    always_comb begin
        w_sdata = 32'd0;
        if (r_state == S_WRITE) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_sdata = r_old;
                    w_sdata[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
                end
                2'b01: begin
                    w_sdata = r_old;
                    w_sdata[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
                end
                default: w_sdata = r_wdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_old    <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr[AW-1:0];
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        if (w_error) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (!req_store) begin
                            r_state <= S_LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_ldata;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_READ: begin
                    r_old   <= mem_ldata;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Directed and randomised self-checking bench for lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    localparam int DEPTH = 2048;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_sdata;
    logic          mem_wren;
    logic [31:0]   mem_ldata;

    logic [31:0]   mem     [DEPTH/4];
    logic [31:0]   ref_mem [DEPTH/4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_sdata  (mem_sdata),
        .mem_wren   (mem_wren),
        .mem_ldata  (mem_ldata)
    );

    assign mem_ldata = mem[mem_addr[AW-1:2]];

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[AW-1:2]] <= mem_sdata;
    end

    // Issue one request from an IDLE cycle and collect its response.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int wr);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hxxxx_xxxx; req_wdata = 32'hxxxx_xxxx;
        lat = 1; wr = 0;
        while (!rsp_valid && lat < 20) begin
            wr += int'(mem_wren);
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            tests++; fails++;
            $display("FAIL req_timeout addr=%h funct3=%0d: no rsp_valid within 20 cycles", a, f3);
        end
        wr += int'(mem_wren);
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_mem_wren got %b want 0", mem_wren); end
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        rst_n = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
        tests++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_rdata, rsp_err); end
    endtask

    task automatic test_round_trip();
        logic [31:0] rd; logic er; int lat, wr;
        logic [2:0]  f3s [5];
        logic [31:0] exp [5];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        exp = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'h0000_00F1, 32'h0000_00F1, 32'h8000_00F1};
        do_req(1'b1, 3'b010, 32'h10, 32'h8000_00F1, rd, er, lat, wr);
        tests++; if (lat != 2 || wr != 1 || er !== 1'b0 || rd !== 32'd0) begin fails++;
            $display("FAIL sw_0x10 lat=%0d wr=%0d err=%b rdata=%h want 2/1/0/0", lat, wr, er, rd); end
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], 32'h10, 32'd0, rd, er, lat, wr);
            tests++; if (rd !== exp[i] || er !== 1'b0 || lat != 2 || wr != 0) begin fails++;
                $display("FAIL load_f3_%0d rdata=%h err=%b lat=%0d wr=%0d want %h/0/2/0", f3s[i], rd, er, lat, wr, exp[i]); end
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd; logic er; int lat, wr;
        do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, er, lat, wr);
        do_req(1'b1, 3'b000, 32'h22, 32'hFFFF_FFAB, rd, er, lat, wr);
        tests++; if (lat != 3 || wr != 1 || er !== 1'b0) begin fails++;
            $display("FAIL sb_timing lat=%0d wr=%0d err=%b want 3/1/0", lat, wr, er); end
        do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'h11AB_3344) begin fails++; $display("FAIL sb_result got %h want 11ab3344", rd); end
        do_req(1'b1, 3'b001, 32'h20, 32'h5555_CDEF, rd, er, lat, wr);
        tests++; if (lat != 3 || wr != 1 || er !== 1'b0) begin fails++;
            $display("FAIL sh_timing lat=%0d wr=%0d err=%b want 3/1/0", lat, wr, er); end
        do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'h11AB_CDEF) begin fails++; $display("FAIL sh_result got %h want 11abcdef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, wr;
        logic        sts [4];
        logic [2:0]  f3s [4];
        logic [31:0] ads [4];
        sts = '{1'b0, 1'b1, 1'b0, 1'b1};
        f3s = '{3'b010, 3'b001, 3'b000, 3'b100};
        ads = '{32'h22, 32'h21, 32'd2048, 32'h24};
        do_req(1'b1, 3'b010, 32'h24, 32'h5555_AAAA, rd, er, lat, wr);
        for (int i = 0; i < 4; i++) begin
            do_req(sts[i], f3s[i], ads[i], 32'hFFFF_FFFF, rd, er, lat, wr);
            tests++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || wr != 0) begin fails++;
                $display("FAIL error_%0d err=%b rdata=%h lat=%0d wr=%0d want 1/0/1/0", i, er, rd, lat, wr); end
        end
        do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'h11AB_CDEF) begin fails++; $display("FAIL err_mem_0x20 got %h want 11abcdef", rd); end
        do_req(1'b0, 3'b010, 32'h24, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'h5555_AAAA) begin fails++; $display("FAIL err_mem_0x24 got %h want 5555aaaa", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat, wr;
        do_req(1'b1, 3'b010, 32'h40, 32'h8001_1234, rd, er, lat, wr);
        rsp_ready = 1'b0;
        do_req(1'b0, 3'b001, 32'h42, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'hFFFF_8001 || lat != 2) begin fails++; $display("FAIL bp_lh rdata=%h lat=%0d want ffff8001/2", rd, lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_8001 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin fails++;
                $display("FAIL bp_hold_%0d valid=%b rdata=%h err=%b ready=%b want 1/ffff8001/0/0", i, rsp_valid, rsp_rdata, rsp_err, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL bp_release ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        do_req(1'b0, 3'b101, 32'h40, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'h0000_1234 || lat != 2) begin fails++; $display("FAIL bp_next rdata=%h lat=%0d want 00001234/2", rd, lat); end
    endtask

    task automatic test_reset_rmw();
        logic [31:0] rd; logic er; int lat, wr;
        do_req(1'b1, 3'b010, 32'h50, 32'hDEAD_BEEF, rd, er, lat, wr);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h51; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (mem_wren !== 1'b1) begin fails++; $display("FAIL rst_rmw_write_state wren=%b want 1", mem_wren); end
        rst_n = 1'b0;
        #1;
        tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL rst_rmw_wren got %b want 0", mem_wren); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL rst_rmw_release ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rmw_no_rsp_%0d valid=%b want 0", i, rsp_valid); end
        end
        do_req(1'b0, 3'b010, 32'h50, 32'd0, rd, er, lat, wr);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rst_rmw_mem got %h want deadbeef", rd); end
    endtask

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] w;
        logic [1:0]  o;
        o  = a[1:0];
        er = (st && f3 > 3'd2) || (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
             (a >= 32'd2048) || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && o != 2'd0);
        rd = 32'd0;
        if (!er) begin
            w = ref_mem[a[10:2]];
            if (st) begin
                if (f3 == 3'd2) w = wd;
                else if (f3 == 3'd1) w = o[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
                else case (o)
                    2'd0: w = {w[31:8], wd[7:0]};
                    2'd1: w = {w[31:16], wd[7:0], w[7:0]};
                    2'd2: w = {w[31:24], wd[7:0], w[15:0]};
                    default: w = {wd[7:0], w[23:0]};
                endcase
                ref_mem[a[10:2]] = w;
            end else begin
                case (f3)
                    3'd0: rd = {{24{w[8*o+7]}}, w[8*o +: 8]};
                    3'd4: rd = {24'd0, w[8*o +: 8]};
                    3'd1: rd = o[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
                    3'd5: rd = o[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
                    default: rd = w;
                endcase
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd, a, wd; logic er, eer, st; logic [2:0] f3; int lat, wr;
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            a  = 32'h400 + 32'(i * 4);
            ref_mem[a[10:2]] = wd;
            do_req(1'b1, 3'b010, a, wd, rd, er, lat, wr);
        end
        for (int i = 0; i < 1000; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 19) == 0) ? 32'd2048 + $urandom_range(0, 4095)
                                              : 32'h400 + $urandom_range(0, 255);
            wd = $urandom;
            model(st, f3, a, wd, erd, eer);
            do_req(st, f3, a, wd, rd, er, lat, wr);
            tests++;
            if (rd !== erd || er !== eer) begin
                fails++;
                if (bad < 10) $display("FAIL b2b_%0d st=%b f3=%0d addr=%h rdata=%h err=%b want %h/%b",
                                       i, st, f3, a, rd, er, erd, eer);
                bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH/4; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        test_reset();
        test_round_trip();
        test_rmw();
        test_errors();
        test_backpressure();
        test_reset_rmw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
